// File: rtl/msoc_irq_pkg.sv
// rtl/msoc_irq_pkg.sv - shared constants and state type for the MSoC interrupt controller
package msoc_irq_pkg;

    localparam logic [2:0] IRQ_ADDR_RAW     = 3'd0;
    localparam logic [2:0] IRQ_ADDR_PENDING = 3'd1;
    localparam logic [2:0] IRQ_ADDR_MASK    = 3'd2;
    localparam logic [2:0] IRQ_ADDR_MODE    = 3'd3;
    localparam logic [2:0] IRQ_ADDR_CLAIM   = 3'd4;
    localparam logic [2:0] IRQ_ADDR_EOI     = 3'd5;

    localparam logic [15:0] IRQ_CLAIM_NONE = 16'h000F;
    localparam int          IRQ_MAX_SRC    = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/msoc_irq_prio_enc.sv
// rtl/msoc_irq_prio_enc.sv - combinational lowest-index-wins priority encoder
module msoc_irq_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] req_i,
    output logic         valid_o,
    output logic [3:0]   vector_o
);

    // Scanning from the top down lets the lowest set index overwrite last.
    always_comb begin
        valid_o  = |req_i;
        vector_o = 4'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) vector_o = 4'(i);
        end
    end

endmodule

// File: rtl/msoc_irq_ctrl.sv
// rtl/msoc_irq_ctrl.sv - Avalon-MM interrupt controller with edge/level capture and claim/EOI
module msoc_irq_ctrl
    import msoc_irq_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic               chipselect,
    input  logic [2:0]         address,
    input  logic               write_n,
    input  logic               read_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    output logic               cpu_irq
);

    logic [NUM_SRC-1:0] src_d_q, pend_q, pend_d, mask_q, mode_q;
    logic [NUM_SRC-1:0] active, rise, w1c, mode_chg, claim_clr;
    logic [15:0]        readdata_q, readdata_d;
    logic               cpu_irq_q;
    irq_state_e         state_q;
    logic               rd_en, wr_en, claim_fire, eoi_fire;
    logic               enc_valid;
    logic [3:0]         enc_vec;
    logic               unused_wdata;

    assign unused_wdata = ^writedata;

    assign rd_en  = chipselect & ~read_n;
    assign wr_en  = chipselect & ~write_n;
    assign active = pend_q & mask_q;
    assign rise   = src_irq & ~src_d_q;

    msoc_irq_prio_enc #(.N(NUM_SRC)) u_prio_enc (
        .req_i    (active),
        .valid_o  (enc_valid),
        .vector_o (enc_vec)
    );

    assign claim_fire = rd_en && (address == IRQ_ADDR_CLAIM) && (state_q == ST_REQ) && enc_valid;
    assign eoi_fire   = wr_en && (address == IRQ_ADDR_EOI) && (state_q == ST_SERVICE);

    // Pending is registered for both modes so level and edge sources share the same latency.
    always_comb begin
        w1c       = '0;
        mode_chg  = '0;
        claim_clr = '0;
        if (wr_en && address == IRQ_ADDR_PENDING) w1c = writedata[NUM_SRC-1:0];
        if (wr_en && address == IRQ_ADDR_MODE)    mode_chg = writedata[NUM_SRC-1:0] ^ mode_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            claim_clr[i] = claim_fire && (enc_vec == 4'(i));
        end
        pend_d = ~mode_chg & ((mode_q & ((pend_q & ~w1c & ~claim_clr) | rise))
                            | (~mode_q & src_irq));
    end

    always_comb begin
        readdata_d = readdata_q;
        if (rd_en) begin
            case (address)
                IRQ_ADDR_RAW:     readdata_d = 16'(src_irq);
                IRQ_ADDR_PENDING: readdata_d = 16'(pend_q);
                IRQ_ADDR_MASK:    readdata_d = 16'(mask_q);
                IRQ_ADDR_MODE:    readdata_d = 16'(mode_q);
                IRQ_ADDR_CLAIM:   readdata_d = claim_fire ? {1'b1, 11'd0, enc_vec} : IRQ_CLAIM_NONE;
                default:          readdata_d = 16'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            src_d_q    <= '0;
            pend_q     <= '0;
            mask_q     <= '0;
            mode_q     <= '0;
            readdata_q <= 16'd0;
        end else begin
            src_d_q    <= src_irq;
            pend_q     <= pend_d;
            readdata_q <= readdata_d;
            if (wr_en && address == IRQ_ADDR_MASK) mask_q <= writedata[NUM_SRC-1:0];
            if (wr_en && address == IRQ_ADDR_MODE) mode_q <= writedata[NUM_SRC-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cpu_irq_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|active) begin
                        state_q   <= ST_REQ;
                        cpu_irq_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (claim_fire) begin
                        state_q   <= ST_SERVICE;
                        cpu_irq_q <= 1'b0;
                    end else if (!(|active)) begin
                        state_q   <= ST_IDLE;
                        cpu_irq_q <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (eoi_fire) state_q <= ST_IDLE;
                    cpu_irq_q <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    cpu_irq_q <= 1'b0;
                end
            endcase
        end
    end

    assign readdata = readdata_q;
    assign cpu_irq  = cpu_irq_q;

endmodule

// File: tb/tb_msoc_irq_ctrl.sv
// tb/tb_msoc_irq_ctrl.sv - randomized and directed bench for msoc_irq_ctrl against a register-level model
module tb_msoc_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  src_irq;
    logic        chipselect;
    logic [2:0]  address;
    logic        write_n;
    logic        read_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        cpu_irq;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: 0 = idle, 1 = request raised, 2 = in service
    int          m_state;
    logic [7:0]  m_pend, m_mask, m_mode, m_prev_src;
    logic [15:0] m_rd;
    logic        m_irq;

    always #5 clk = ~clk;

    msoc_irq_ctrl #(.NUM_SRC(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .src_irq    (src_irq),
        .chipselect (chipselect),
        .address    (address),
        .write_n    (write_n),
        .read_n     (read_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .cpu_irq    (cpu_irq)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic int lowest_active(input logic [7:0] act);
        for (int i = 0; i < 8; i++) if (act[i]) return i;
        return -1;
    endfunction

    task automatic model_step();
        logic [7:0] act;
        logic [7:0] next_pend;
        int  v;
        bit  rd, wr, claim;
        act   = m_pend & m_mask;
        v     = lowest_active(act);
        rd    = chipselect && !read_n;
        wr    = chipselect && !write_n;
        claim = rd && address == 3'd4 && m_state == 1 && v >= 0;
        if (rd) begin
            case (address)
                3'd0: m_rd = {8'd0, src_irq};
                3'd1: m_rd = {8'd0, m_pend};
                3'd2: m_rd = {8'd0, m_mask};
                3'd3: m_rd = {8'd0, m_mode};
                3'd4: m_rd = claim ? (16'h8000 + 16'(v)) : 16'h000F;
                default: m_rd = 16'd0;
            endcase
        end
        for (int i = 0; i < 8; i++) begin
            bit rose, changed, cleared;
            rose    = src_irq[i] && !m_prev_src[i];
            changed = wr && address == 3'd3 && (writedata[i] != m_mode[i]);
            cleared = (wr && address == 3'd1 && writedata[i]) || (claim && v == i);
            if (changed)        next_pend[i] = 1'b0;
            else if (m_mode[i]) next_pend[i] = rose ? 1'b1 : (m_pend[i] && !cleared);
            else                next_pend[i] = src_irq[i];
        end
        case (m_state)
            0: if (act != 0) m_state = 1;
            1: if (claim) m_state = 2; else if (act == 0) m_state = 0;
            default: if (wr && address == 3'd5) m_state = 0;
        endcase
        if (wr && address == 3'd2) m_mask = writedata[7:0];
        if (wr && address == 3'd3) m_mode = writedata[7:0];
        m_pend     = next_pend;
        m_prev_src = src_irq;
        if (!reset_n) begin
            m_state = 0; m_pend = 0; m_mask = 0; m_mode = 0; m_prev_src = 0; m_rd = 0;
        end
        m_irq = (m_state == 1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model_rd", readdata, m_rd);
        check("model_irq", {15'd0, cpu_irq}, {15'd0, m_irq});
    endtask

    task automatic bus_idle();
        chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1; address = 3'd0; writedata = 16'd0;
    endtask

    task automatic reg_rd(input logic [2:0] a, output logic [15:0] d);
        chipselect = 1'b1; read_n = 1'b0; address = a;
        tick();
        bus_idle();
        d = readdata;
    endtask

    task automatic reg_wr(input logic [2:0] a, input logic [15:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick();
        bus_idle();
    endtask

    initial begin
        logic [15:0] d;
        bus_idle();
        src_irq = 8'd0;
        reset_n = 1'b0;
        m_state = 0; m_pend = 0; m_mask = 0; m_mode = 0; m_prev_src = 0; m_rd = 0; m_irq = 0;
        @(negedge clk);
        tick(); tick();
        reset_n = 1'b1;

        // Reset values
        check("rst_readdata", readdata, 16'h0000);
        src_irq = 8'h5A;
        reg_rd(3'd0, d); check("rst_raw", d, 16'h005A);
        src_irq = 8'h00;
        tick();
        reg_rd(3'd1, d); check("rst_pending", d, 16'h0000);
        reg_rd(3'd2, d); check("rst_mask", d, 16'h0000);
        reg_rd(3'd3, d); check("rst_mode", d, 16'h0000);
        reg_rd(3'd4, d); check("rst_claim", d, 16'h000F);
        check("rst_irq", {15'd0, cpu_irq}, 16'd0);

        // Level source 0: two-edge latency, claim, EOI with level still high
        reg_wr(3'd2, 16'h0001);
        reg_wr(3'd3, 16'h0000);
        src_irq = 8'h01;
        tick(); check("lvl_irq_k", {15'd0, cpu_irq}, 16'd0);
        tick(); check("lvl_irq_k1", {15'd0, cpu_irq}, 16'd1);
        reg_rd(3'd4, d); check("lvl_claim", d, 16'h8000);
        check("lvl_irq_claimed", {15'd0, cpu_irq}, 16'd0);
        reg_wr(3'd5, 16'h0000);
        check("lvl_irq_eoi", {15'd0, cpu_irq}, 16'd0);
        tick(); check("lvl_irq_reraise", {15'd0, cpu_irq}, 16'd1);
        src_irq = 8'h00;
        tick(); tick();
        check("lvl_withdrawn", {15'd0, cpu_irq}, 16'd0);

        // Edge sources 5 and 2 pulsed together
        reg_wr(3'd3, 16'h0024);
        reg_wr(3'd2, 16'h0024);
        src_irq = 8'h24;
        tick();
        src_irq = 8'h00;
        tick(); tick();
        reg_rd(3'd4, d); check("edge_claim2", d, 16'h8002);
        reg_wr(3'd5, 16'h0000);
        tick();
        reg_rd(3'd4, d); check("edge_claim5", d, 16'h8005);
        reg_wr(3'd5, 16'h0000);
        reg_rd(3'd1, d); check("edge_pend_clear", d, 16'h0000);
        tick(); check("edge_irq_quiet", {15'd0, cpu_irq}, 16'd0);

        // W1C racing a fresh rising edge on source 3
        reg_wr(3'd2, 16'h0000);
        reg_wr(3'd3, 16'h0008);
        src_irq = 8'h08; tick();
        src_irq = 8'h00; tick();
        src_irq = 8'h08;
        reg_wr(3'd1, 16'h0008);
        src_irq = 8'h00;
        reg_rd(3'd1, d); check("w1c_set_wins", d, 16'h0008);
        reg_wr(3'd1, 16'h0008);
        reg_rd(3'd1, d); check("w1c_clears", d, 16'h0000);

        // Level source 1 withdrawn before claim
        reg_wr(3'd3, 16'h0000);
        reg_wr(3'd2, 16'h0002);
        src_irq = 8'h02; tick(); tick();
        check("wd_irq_up", {15'd0, cpu_irq}, 16'd1);
        src_irq = 8'h00; tick(); tick();
        check("wd_irq_down", {15'd0, cpu_irq}, 16'd0);
        reg_rd(3'd4, d); check("wd_claim_none", d, 16'h000F);

        // Reset while in service
        src_irq = 8'h02; tick(); tick();
        reg_rd(3'd4, d); check("svc_claim1", d, 16'h8001);
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        check("svc_rst_irq", {15'd0, cpu_irq}, 16'd0);
        check("svc_rst_rd", readdata, 16'h0000);
        reg_rd(3'd2, d); check("svc_rst_mask", d, 16'h0000);
        reg_wr(3'd5, 16'h0000);
        tick(); check("svc_eoi_ignored", {15'd0, cpu_irq}, 16'd0);
        reg_rd(3'd4, d); check("svc_claim_idle", d, 16'h000F);

        // Randomized traffic checked cycle by cycle against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(3) == 0) src_irq = 8'($urandom);
            chipselect = ($urandom_range(1) == 1);
            read_n     = ($urandom_range(2) == 0);
            write_n    = ($urandom_range(2) == 0);
            address    = 3'($urandom_range(7));
            writedata  = 16'($urandom);
            reset_n    = ($urandom_range(299) != 0);
            tick();
        end
        reset_n = 1'b1;
        bus_idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
